fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 43 ++++
 rtl/fetch_unit.sv | 89 ++++++++
 2 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the fetch unit: opcodes, RAM request codes,
// sequencer state encodings and the PC-advance rule.
package fetch_unit_pkg;

   // Opcodes (IR[3:0])
   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_LDA = 4'h3;
   localparam logic [3:0] OP_LD  = 4'h4;
   localparam logic [3:0] OP_ST  = 4'h5;
   localparam logic [3:0] OP_CBR = 4'h6;

   // RAM request codes from the control stage
   localparam logic [1:0] RAM_NONE  = 2'd0;
   localparam logic [1:0] RAM_READ  = 2'd1;
   localparam logic [1:0] RAM_WRITE = 2'd2;

   // Sequencer state encodings
   localparam logic [1:0] FS_FETCH = 2'd0;
   localparam logic [1:0] FS_EXEC  = 2'd1;
   localparam logic [1:0] FS_MEM   = 2'd2;

   typedef enum logic [1:0] {
      S_FETCH = FS_FETCH,
      S_EXEC  = FS_EXEC,
      S_MEM   = FS_MEM
   } fetch_state_t;

   // Next PC at commit: taken jump wins, LDA skips its immediate word.
   function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                           input logic [3:0]  inst,
                                           input logic        do_jump,
                                           input logic [31:0] jump_addr);
      if (do_jump)
         return jump_addr;
      else if (inst == OP_LDA)
         return pc + 32'd2;
      else
         return pc + 32'd1;
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: fetches a word at PC, holds it in IR while
// the control stage executes, optionally waits for a data access, then
// commits and advances PC.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_ram_data,
   input  logic        i_ram_ack,
   input  logic [1:0]  i_ctl_ram_do,
   input  logic        i_do_jump,
   input  logic [31:0] i_jump_addr,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_inc,
   output logic        o_fetch_req,
   output logic        o_ram_sel,
   output logic [3:0]  o_inst,
   output logic [3:0]  o_r0_sel,
   output logic [3:0]  o_r1_sel,
   output logic        o_exec_we,
   output logic        o_busy
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  ir;
   logic         commit;
   logic         ir_hi_unused;

   // Commit happens in S_EXEC without a data access, or on the ack of S_MEM;
   // jump inputs are only looked at in that cycle.
   always_comb begin
      commit = 1'b0;
      if (state == S_EXEC && i_ctl_ram_do == RAM_NONE)
         commit = 1'b1;
      else if (state == S_MEM && i_ram_ack)
         commit = 1'b1;
   end

   // Sequencer: state, PC and IR registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= S_FETCH;
         pc    <= RESET_PC;
         ir    <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (i_ram_ack) begin
                  ir    <= i_ram_data;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (commit) begin
                  pc    <= next_pc(pc, ir[3:0], i_do_jump, i_jump_addr);
                  state <= S_FETCH;
               end else begin
                  state <= S_MEM;
               end
            end
            S_MEM: begin
               if (commit) begin
                  pc    <= next_pc(pc, ir[3:0], i_do_jump, i_jump_addr);
                  state <= S_FETCH;
               end
            end
            default: state <= S_FETCH;
         endcase
      end
   end

   assign o_pc        = pc;
   assign o_pc_inc    = pc + 32'd1;
   assign o_fetch_req = (state == S_FETCH);
   assign o_ram_sel   = (state == S_MEM) ||
                        (state == S_EXEC && i_ctl_ram_do != RAM_NONE);
   assign o_inst      = ir[3:0];
   assign o_r0_sel    = ir[7:4];
   assign o_r1_sel    = ir[11:8];
   assign o_exec_we   = commit;
   assign o_busy      = (state != S_EXEC);

   assign ir_hi_unused = ^ir[31:12];

endmodule
